// File: rtl/gpio_rgb_ctrl_pkg.sv
// gpio_rgb_ctrl_pkg
//   Shared definitions for the GPIO-mapped RGB LED / switch controller:
//   command opcodes, channel modes, command-word field layout and the
//   bit positions of the ack and status fields in the response word.
package gpio_rgb_ctrl_pkg;

   localparam int NB_GPIOS = 32;

   typedef enum logic [2:0] {
      OP_NOP         = 3'd0,
      OP_SET_RGB     = 3'd1,
      OP_SET_MODE    = 3'd2,
      OP_SET_BLINK   = 3'd3,
      OP_READ_SW     = 3'd4,
      OP_READ_STATUS = 3'd5,
      OP_RSVD6       = 3'd6,
      OP_RSVD7       = 3'd7
   } opcode_e;

   typedef enum logic {
      MODE_STATIC = 1'b0,
      MODE_BLINK  = 1'b1
   } mode_e;

   // Command word layout, MSB first:
   // [31] strobe | [30:28] opcode | [27:24] channel | [23:16] R | [15:8] G | [7:0] B
   typedef struct packed {
      logic       strobe;
      opcode_e    op;
      logic [3:0] ch;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } cmd_t;

   localparam int BIT_ACK         = 31;
   localparam int ST_BIT_ERR      = 0;
   localparam int ST_BIT_PHASE    = 1;
   localparam int ST_NRGB_LSB     = 8;
   localparam int SW_LEVEL_LSB    = 0;
   localparam int SW_EVENT_LSB    = 8;

   function automatic cmd_t unpack_cmd(input logic [NB_GPIOS-1:0] word);
      return cmd_t'(word);
   endfunction

endpackage

// File: rtl/gpio_rgb_ctrl_if.sv
// gpio_rgb_ctrl_if
//   GPIO word pair between the microcontroller and the RGB controller.
//     in_gpo  : command word, micro -> controller
//     out_gpi : response word, controller -> micro (bit 31 = ack toggle)
//   master = micro side, slave = controller side.
interface gpio_rgb_ctrl_if;
   import gpio_rgb_ctrl_pkg::*;

   logic [NB_GPIOS-1:0] in_gpo;
   logic [NB_GPIOS-1:0] out_gpi;

   modport master (output in_gpo, input out_gpi);
   modport slave  (input in_gpo, output out_gpi);
endinterface

// File: rtl/gpio_rgb_ctrl_sw_debounce.sv
// sw_debounce
//   One switch: 2-FF synchroniser followed by a stability counter.
//   The level is accepted only after DEBOUNCE_CYC consecutive clocks that
//   disagree with the current debounced level.
//   Ports:
//     clockdsp        clock
//     in_reset        asynchronous reset, active-low
//     i_raw           raw switch input (asynchronous)
//     o_level         debounced level
//     o_change_pulse  high for the one clock on whose edge o_level flips
module sw_debounce #(
   parameter int DEBOUNCE_CYC = 100000
) (
   input  logic clockdsp,
   input  logic in_reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_change_pulse
);
   localparam int NB_CNT = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(DEBOUNCE_CYC - 1);

   logic [1:0]        sync_q;
   logic [NB_CNT-1:0] cnt_q;

   // Down-counter: reloaded while the input agrees with the accepted level,
   // so reaching zero means DEBOUNCE_CYC disagreeing clocks in a row.
   assign o_change_pulse = (sync_q[1] != o_level) && (cnt_q == '0);

   always_ff @(posedge clockdsp or negedge in_reset) begin
      if (!in_reset) begin
         sync_q  <= '0;
         cnt_q   <= CNT_LOAD;
         o_level <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], i_raw};
         if (sync_q[1] == o_level) begin
            cnt_q <= CNT_LOAD;
         end else if (o_change_pulse) begin
            o_level <= sync_q[1];
            cnt_q   <= CNT_LOAD;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end
endmodule

// File: rtl/gpio_rgb_ctrl.sv
// gpio_rgb_ctrl
//   GPIO-mapped RGB LED and switch controller. Decodes strobed commands from
//   the micro GPIO word, holds per-channel duties and modes, drives a
//   free-running PWM with wrap-aligned duty updates, gates blink-mode
//   channels with a programmable half-period, and reports debounced
//   switches with sticky change events.
//   Ports:
//     clockdsp      application clock
//     in_reset      asynchronous reset, active-low
//     gpio          slave side of the GPIO word pair (in_gpo / out_gpi)
//     i_sw          raw switches (asynchronous)
//     out_leds_rgb  channel c: bit 3c = R, 3c+1 = G, 3c+2 = B
module gpio_rgb_ctrl
   import gpio_rgb_ctrl_pkg::*;
#(
   parameter int N_RGB        = 4,
   parameter int NB_PWM       = 8,
   parameter int NB_SW        = 4,
   parameter int DEBOUNCE_CYC = 100000,
   parameter int NB_BLINK     = 24,
   parameter int BLINK_RST    = 12500000
) (
   input  logic               clockdsp,
   input  logic               in_reset,
   gpio_rgb_ctrl_if.slave     gpio,
   input  logic [NB_SW-1:0]   i_sw,
   output logic [3*N_RGB-1:0] out_leds_rgb
);
   cmd_t                cmd;
   logic                strobe_q;
   logic                fire;
   logic                ch_ok;
   logic                do_rgb;
   logic                do_mode;
   logic                do_blink;
   logic                do_rd_sw;
   logic                do_rd_st;
   logic                err_set;

   logic                ack_q;
   logic [NB_GPIOS-2:0] gpi_q;
   logic                err_q;

   logic [NB_PWM-1:0]   duty_q   [N_RGB][3];
   logic [NB_PWM-1:0]   shadow_q [N_RGB][3];
   logic [NB_PWM-1:0]   col_duty [3];
   logic [N_RGB-1:0]    blink_en_q;
   logic [NB_PWM-1:0]   pwm_cnt_q;

   logic [NB_BLINK-1:0] half_q;
   logic [NB_BLINK-1:0] half_new;
   logic [NB_BLINK-1:0] blink_cnt_q;
   logic                phase_q;

   logic [NB_SW-1:0]    sw_level;
   logic [NB_SW-1:0]    sw_pulse;
   logic [NB_SW-1:0]    sw_evt_q;
   logic [7:0]          sw_lvl8;
   logic [7:0]          sw_evt8;

   // ---------------- command decode ----------------
   assign cmd      = unpack_cmd(gpio.in_gpo);
   assign fire     = cmd.strobe & ~strobe_q;
   assign ch_ok    = int'(cmd.ch) < N_RGB;
   assign do_rgb   = fire && (cmd.op == OP_SET_RGB)  && ch_ok;
   assign do_mode  = fire && (cmd.op == OP_SET_MODE) && ch_ok;
   assign do_blink = fire && (cmd.op == OP_SET_BLINK);
   assign do_rd_sw = fire && (cmd.op == OP_READ_SW);
   assign do_rd_st = fire && (cmd.op == OP_READ_STATUS);
   assign err_set  = fire && ((((cmd.op == OP_SET_RGB) || (cmd.op == OP_SET_MODE)) && !ch_ok)
                              || (cmd.op == OP_RSVD6) || (cmd.op == OP_RSVD7));

   assign half_new = (gpio.in_gpo[NB_BLINK-1:0] == '0) ? NB_BLINK'(1) : gpio.in_gpo[NB_BLINK-1:0];

   assign col_duty[0] = cmd.r[7 -: NB_PWM];
   assign col_duty[1] = cmd.g[7 -: NB_PWM];
   assign col_duty[2] = cmd.b[7 -: NB_PWM];

   always_comb begin
      sw_lvl8 = '0;
      sw_evt8 = '0;
      sw_lvl8[NB_SW-1:0] = sw_level;
      sw_evt8[NB_SW-1:0] = sw_evt_q;
   end

   assign gpio.out_gpi = {ack_q, gpi_q};

   // ---------------- command registers ----------------
   always_ff @(posedge clockdsp or negedge in_reset) begin
      if (!in_reset) begin
         // Strobe history comes up as "high" so a strobe still asserted across
         // reset release is treated as already seen and cannot fire.
         strobe_q   <= 1'b1;
         ack_q      <= 1'b0;
         gpi_q      <= '0;
         err_q      <= 1'b0;
         sw_evt_q   <= '0;
         blink_en_q <= '0;
         for (int c = 0; c < N_RGB; c++) begin
            for (int k = 0; k < 3; k++) begin
               duty_q[c][k] <= '0;
            end
         end
      end else begin
         strobe_q <= cmd.strobe;
         // Clears lose to sets landing on the same edge.
         err_q    <= (err_q & ~do_rd_st) | err_set;
         sw_evt_q <= (do_rd_sw ? '0 : sw_evt_q) | sw_pulse;
         if (fire) begin
            ack_q <= ~ack_q;
         end
         if (do_rd_sw) begin
            gpi_q <= {15'd0, sw_evt8, sw_lvl8};
         end else if (do_rd_st) begin
            gpi_q <= {19'd0, 4'(N_RGB - 1), 6'd0, phase_q, err_q};
         end
         for (int c = 0; c < N_RGB; c++) begin
            if (int'(cmd.ch) == c) begin
               if (do_rgb) begin
                  for (int k = 0; k < 3; k++) begin
                     duty_q[c][k] <= col_duty[k];
                  end
               end
               if (do_mode) begin
                  blink_en_q[c] <= (cmd.b[0] == MODE_BLINK);
               end
            end
         end
      end
   end

   // ---------------- blink timebase ----------------
   // Down-counter from half-1 to 0; the phase toggles on the terminal count.
   always_ff @(posedge clockdsp or negedge in_reset) begin
      if (!in_reset) begin
         half_q      <= NB_BLINK'(BLINK_RST);
         blink_cnt_q <= NB_BLINK'(BLINK_RST - 1);
         phase_q     <= 1'b0;
      end else if (do_blink) begin
         half_q      <= half_new;
         blink_cnt_q <= half_new - 1'b1;
      end else if (blink_cnt_q == '0) begin
         blink_cnt_q <= half_q - 1'b1;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q - 1'b1;
      end
   end

   // ---------------- PWM ----------------
   // Shadow duties reload only when the counter is at its maximum, so a new
   // duty starts on a clean period boundary.
   always_ff @(posedge clockdsp or negedge in_reset) begin
      if (!in_reset) begin
         pwm_cnt_q    <= '0;
         out_leds_rgb <= '0;
         for (int c = 0; c < N_RGB; c++) begin
            for (int k = 0; k < 3; k++) begin
               shadow_q[c][k] <= '0;
            end
         end
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         if (pwm_cnt_q == {NB_PWM{1'b1}}) begin
            shadow_q <= duty_q;
         end
         for (int c = 0; c < N_RGB; c++) begin
            for (int k = 0; k < 3; k++) begin
               out_leds_rgb[3*c+k] <= (shadow_q[c][k] > pwm_cnt_q) && (!blink_en_q[c] || phase_q);
            end
         end
      end
   end

   // ---------------- switches ----------------
   for (genvar s = 0; s < NB_SW; s++) begin : g_sw
      sw_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
         .clockdsp       (clockdsp),
         .in_reset       (in_reset),
         .i_raw          (i_sw[s]),
         .o_level        (sw_level[s]),
         .o_change_pulse (sw_pulse[s])
      );
   end

endmodule
